// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma stepping controller.
//
// Contents:
//   letter_t     - 5-bit rotor position (0..25 = A..Z)
//   LETTERS      - alphabet size (26)
//   R_NOTCH_DEFAULT / M_NOTCH_DEFAULT - default turnover positions (V / E)
//   state_t      - controller FSM state encoding
//   letter_inc   - mod-26 increment
//   letter_wrap  - folds a 5-bit value >= 26 back into 0..5

package enigma_pkg;

    localparam int LETTERS         = 26;
    localparam int R_NOTCH_DEFAULT = 21;
    localparam int M_NOTCH_DEFAULT = 4;

    typedef logic [4:0] letter_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ENCODE = 2'd2
    } state_t;

    function automatic letter_t letter_inc(input letter_t v);
        return (v == letter_t'(LETTERS - 1)) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic letter_t letter_wrap(input letter_t v);
        return (v >= letter_t'(LETTERS)) ? v - letter_t'(LETTERS) : v;
    endfunction

endpackage

// File: rtl/enigma_step_logic.sv
// Combinational rotor stepping: given the current positions, produces the
// positions after one keypress and a flag per rotor that advanced.
//
// Configuration macro: ENIGMA_DOUBLE_STEP_EN
//   defined   - historical double-step: a middle rotor sitting on its notch
//               advances itself and the left rotor on the next keypress.
//   undefined - pure odometer carry.
//
// Ports:
//   pos_l/m/r  in  current positions
//   nxt_l/m/r  out positions after the step
//   adv_l/m/r  out rotor advanced on this step

module enigma_step_logic
    import enigma_pkg::*;
#(
    parameter int R_NOTCH = R_NOTCH_DEFAULT,
    parameter int M_NOTCH = M_NOTCH_DEFAULT
) (
    input  letter_t pos_l,
    input  letter_t pos_m,
    input  letter_t pos_r,
    output letter_t nxt_l,
    output letter_t nxt_m,
    output letter_t nxt_r,
    output logic    adv_l,
    output logic    adv_m,
    output logic    adv_r
);

    logic r_at_notch;
    logic m_at_notch;

    assign r_at_notch = (pos_r == letter_t'(R_NOTCH));
    assign m_at_notch = (pos_m == letter_t'(M_NOTCH));

    always_comb begin
        adv_r = 1'b1;
`ifdef ENIGMA_DOUBLE_STEP_EN
        adv_m = r_at_notch | m_at_notch;
        adv_l = m_at_notch;
`else
        adv_m = r_at_notch;
        adv_l = r_at_notch & m_at_notch;
`endif
        nxt_r = letter_inc(pos_r);
        nxt_m = adv_m ? letter_inc(pos_m) : pos_m;
        nxt_l = adv_l ? letter_inc(pos_l) : pos_l;
    end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Stepping controller for the three-rotor Enigma datapath.
//
// Holds rotor positions, accepts keypresses and position loads, steps the
// rotors, waits SETTLE_CYCLES for the rotor/reflector path to settle and
// then strobes enc_valid for one cycle.
//
// Handshake: a request transfers on a rising clock edge where valid and
// ready are both high; requesters hold valid until then. Both ready
// outputs are high only in IDLE. A load wins over a simultaneous key.
//
// Configuration macro: ENIGMA_DOUBLE_STEP_EN (see enigma_step_logic).
//
// Ports:
//   clock, resetn           clock, async active-low reset
//   key_valid / key_ready   keypress handshake
//   set_valid / set_ready   position-load handshake, set_pos = {l, m, r}
//   pos_l/m/r               current rotor positions (0..25)
//   step_l/m/r              one-cycle pulse per rotor that advanced
//   enc_valid               one-cycle strobe, positions settled
//   key_count               accepted keys since reset or last load
//   fsm_state               current FSM state (debug)

module enigma_step_ctrl
    import enigma_pkg::*;
#(
    parameter int R_NOTCH       = R_NOTCH_DEFAULT,
    parameter int M_NOTCH       = M_NOTCH_DEFAULT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic        set_valid,
    output logic        set_ready,
    input  logic [14:0] set_pos,
    output letter_t     pos_l,
    output letter_t     pos_m,
    output letter_t     pos_r,
    output logic        step_l,
    output logic        step_m,
    output logic        step_r,
    output logic        enc_valid,
    output logic [15:0] key_count,
    output logic [1:0]  fsm_state
);

    state_t     state;
    logic [3:0] settle_cnt;

    letter_t nxt_l, nxt_m, nxt_r;
    logic    adv_l, adv_m, adv_r;

    enigma_step_logic #(
        .R_NOTCH(R_NOTCH),
        .M_NOTCH(M_NOTCH)
    ) u_step (
        .pos_l(pos_l),
        .pos_m(pos_m),
        .pos_r(pos_r),
        .nxt_l(nxt_l),
        .nxt_m(nxt_m),
        .nxt_r(nxt_r),
        .adv_l(adv_l),
        .adv_m(adv_m),
        .adv_r(adv_r)
    );

    assign fsm_state = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            pos_l      <= '0;
            pos_m      <= '0;
            pos_r      <= '0;
            step_l     <= 1'b0;
            step_m     <= 1'b0;
            step_r     <= 1'b0;
            enc_valid  <= 1'b0;
            key_count  <= '0;
            key_ready  <= 1'b1;
            set_ready  <= 1'b1;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            step_l    <= 1'b0;
            step_m    <= 1'b0;
            step_r    <= 1'b0;
            enc_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (set_valid) begin
                        pos_l     <= letter_wrap(set_pos[14:10]);
                        pos_m     <= letter_wrap(set_pos[9:5]);
                        pos_r     <= letter_wrap(set_pos[4:0]);
                        key_count <= '0;
                    end else if (key_valid) begin
                        pos_l      <= nxt_l;
                        pos_m      <= nxt_m;
                        pos_r      <= nxt_r;
                        step_l     <= adv_l;
                        step_m     <= adv_m;
                        step_r     <= adv_r;
                        key_count  <= key_count + 16'd1;
                        // Counts down to zero over SETTLE_CYCLES cycles.
                        settle_cnt <= 4'(SETTLE_CYCLES - 1);
                        key_ready  <= 1'b0;
                        set_ready  <= 1'b0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        enc_valid <= 1'b1;
                        state     <= ST_ENCODE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                ST_ENCODE: begin
                    key_ready <= 1'b1;
                    set_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    key_ready <= 1'b1;
                    set_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
